// File: rtl/imm_decode_pipe_if.sv
// Handshake bundle for imm_decode_pipe: the instruction-in channel and the
// decoded-out channel. The decoder connects through the slave modport; the
// producer/consumer side (fetch stage, EX stage, or a bench) uses master.
interface imm_decode_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
);
    // instruction-in channel
    logic              IN_VALID;
    logic              IN_READY;
    logic [31:0]       IN_INSTR;
    logic [TAG_W-1:0]  IN_TAG;

    // decoded-out channel
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [XLEN-1:0]   OUT_IMM;
    logic [2:0]        OUT_FMT;
    logic              OUT_ILLEGAL;
    logic [TAG_W-1:0]  OUT_TAG;

    modport master (
        output IN_VALID, IN_INSTR, IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_IMM, OUT_FMT, OUT_ILLEGAL, OUT_TAG
    );

    modport slave (
        input  IN_VALID, IN_INSTR, IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, OUT_IMM, OUT_FMT, OUT_ILLEGAL, OUT_TAG
    );
endinterface

// File: rtl/imm_decode_pipe.sv
// Pipelined RISC-V immediate decoder (ID stage).
// One instruction per cycle in; registered immediate/format/illegal/tag out.
// A single skid register behind the output register absorbs one beat of
// backpressure so IN_READY is driven only from state, never from OUT_READY.
module imm_decode_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic           FLUSH,
    imm_decode_pipe_if.slave io
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_Z = 3'd6,
        FMT_X = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_OP        = 7'b0110011;
    localparam logic [6:0] OP_OP_32     = 7'b0111011;
    localparam logic [6:0] OP_FENCE     = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [31:0]      instr;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             is_shift;
    logic [XLEN-1:0]  dec_imm;
    fmt_e             dec_fmt;
    logic             dec_illegal;

    assign instr    = io.IN_INSTR;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Classify the format and build the extended immediate.
    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_X;
        dec_illegal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec_fmt = FMT_U;
                // sign-extended from bit 31 on RV64
                dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                dec_fmt = FMT_J;
                dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                         instr[30:21], 1'b0}));
            end
            OP_JALR, OP_LOAD: begin
                dec_fmt = FMT_I;
                dec_imm = XLEN'($signed(instr[31:20]));
            end
            OP_OP_IMM: begin
                dec_fmt = FMT_I;
                if (is_shift) begin
                    // RV64 shifts carry a 6-bit shamt; RV32 only 5 bits
                    dec_imm = (XLEN == 64) ? XLEN'(instr[25:20])
                                           : XLEN'(instr[24:20]);
                end else begin
                    dec_imm = XLEN'($signed(instr[31:20]));
                end
            end
            OP_OP_IMM_32: begin
                dec_fmt = FMT_I;
                if (is_shift) begin
                    dec_imm = XLEN'(instr[24:20]);
                end else begin
                    dec_imm = XLEN'($signed(instr[31:20]));
                end
            end
            OP_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OP_BRANCH: begin
                dec_fmt = FMT_B;
                dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                         instr[11:8], 1'b0}));
            end
            OP_OP, OP_OP_32, OP_FENCE: begin
                dec_fmt = FMT_R;
            end
            OP_SYSTEM: begin
                if (funct3[2]) begin
                    dec_fmt = FMT_Z;
                    dec_imm = XLEN'(instr[19:15]);
                end else begin
                    dec_fmt = FMT_R;
                end
            end
            default: begin
                dec_fmt     = FMT_X;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register and skid register
    // ------------------------------------------------------------------
    logic              out_valid;
    logic [XLEN-1:0]   out_imm;
    fmt_e              out_fmt;
    logic              out_illegal;
    logic [TAG_W-1:0]  out_tag;

    logic              skid_valid;
    logic [XLEN-1:0]   skid_imm;
    fmt_e              skid_fmt;
    logic              skid_illegal;
    logic [TAG_W-1:0]  skid_tag;

    logic in_ready;
    logic in_fire;
    logic out_free;
    logic out_load_skid;
    logic out_load_in;
    logic skid_load;

    assign in_ready = !skid_valid;
    assign in_fire  = io.IN_VALID && in_ready;
    assign out_free = !out_valid || io.OUT_READY;

    // Steer each cycle's load: a held skid entry always refills the output
    // first; a new input goes straight to the output when it is free, and
    // to the skid only when the output is stalled.
    always_comb begin
        out_load_skid = 1'b0;
        out_load_in   = 1'b0;
        skid_load     = 1'b0;
        if (out_free) begin
            if (skid_valid) begin
                out_load_skid = 1'b1;
            end else if (in_fire) begin
                out_load_in = 1'b1;
            end
        end else if (in_fire) begin
            skid_load = 1'b1;
        end
    end

    // Valid bits: reset and flush both empty the pipe.
    always_ff @(posedge CLK) begin
        if (!RESET_N || FLUSH) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (out_free) begin
                out_valid <= out_load_skid || out_load_in;
            end
            if (out_load_skid) begin
                skid_valid <= 1'b0;
            end else if (skid_load) begin
                skid_valid <= 1'b1;
            end
        end
    end

    // Payload registers: cleared by reset, left untouched by flush.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            out_imm      <= '0;
            out_fmt      <= FMT_R;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_R;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else if (!FLUSH) begin
            if (out_load_skid) begin
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_illegal;
                out_tag     <= skid_tag;
            end else if (out_load_in) begin
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_illegal;
                out_tag     <= io.IN_TAG;
            end
            if (skid_load) begin
                skid_imm     <= dec_imm;
                skid_fmt     <= dec_fmt;
                skid_illegal <= dec_illegal;
                skid_tag     <= io.IN_TAG;
            end
        end
    end

    assign io.IN_READY    = in_ready;
    assign io.OUT_VALID   = out_valid;
    assign io.OUT_IMM     = out_imm;
    assign io.OUT_FMT     = out_fmt;
    assign io.OUT_ILLEGAL = out_illegal;
    assign io.OUT_TAG     = out_tag;

endmodule
